// File: rtl/dma_io_peripheral.sv
// dma_io_peripheral
//   Device-side end of a 4-channel DREQ/DACK/IOR_N/IOW_N DMA bus.
//   - Raises DREQ[CHANNEL] when a transfer is possible and waits for DACK.
//   - Sources TX FIFO data on IOR_N strobes (device -> memory).
//   - Sinks bus data into the RX FIFO on IOW_N strobes (memory -> device).
//   - EOP_N terminates the run; the block then stays quiet until enable is re-armed.
//
// Ports
//   CLK, RESET         clock; synchronous active-high reset
//   DREQ[3:0]          request; only bit CHANNEL is ever driven
//   DACK[3:0]          acknowledge (one-hot, active-high)
//   IOR_N, IOW_N       bus read / write strobes (active-low)
//   EOP_N              end of process (active-low)
//   DB_IN              bus data sampled during IOW_N
//   DB_OUT, DB_OE      bus data and drive enable during IOR_N
//   enable, dir        arm transfers; dir=1 device->memory, 0 memory->device
//   tx_data/valid/ready  local push into the TX FIFO
//   rx_data/valid/ready  local pop from the RX FIFO
//   done               one-cycle pulse when an EOP-terminated transfer completes
//   state_dbg          current FSM state encoding
//
// Handshake: a local FIFO beat happens on the rising CLK edge where
// valid & ready are both high; valid never waits for ready, and ready never
// waits for valid.

module dma_io_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count_nxt,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Push and pop in the same cycle are both honoured.
  assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign empty     = (count == '0);
  assign full      = (count == DEPTH[AW:0]);
  assign head      = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end
endmodule

module dma_io_peripheral #(
  parameter int CHANNEL     = 0,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int DEMAND_MODE = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  output logic [3:0]                 DREQ,
  input  logic [3:0]                 DACK,
  input  logic                       IOR_N,
  input  logic                       IOW_N,
  input  logic                       EOP_N,
  input  logic [DATA_W-1:0]          DB_IN,
  output logic [DATA_W-1:0]          DB_OUT,
  output logic                       DB_OE,
  input  logic                       enable,
  input  logic                       dir,
  input  logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [DATA_W-1:0]          rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic                       done,
  output logic [2:0]                 state_dbg
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_ACK     = 3'd2,
    S_STROBE  = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              ldir;
  logic [DATA_W-1:0] cap;
  logic              eop_seen;
  logic              armed;
  logic              enable_q;

  logic              dack;
  logic              rd_strobe;
  logic              wr_strobe;
  logic              xfer_dir;
  logic              strobe_ok;
  logic              strobe_high;
  logic              xfer_end;
  logic              eop_now;
  logic              can_idle;
  logic              can_after;

  logic              tx_push;
  logic              tx_pop;
  logic              tx_empty;
  logic              tx_full;
  logic [DATA_W-1:0] tx_head;
  logic [CW-1:0]     tx_cnt_nxt;

  logic              rx_push;
  logic              rx_pop;
  logic              rx_empty;
  logic              rx_full;
  logic [CW-1:0]     rx_cnt_nxt;

  // Only our own DACK bit matters; the others belong to other devices.
  logic unused_dack;
  assign unused_dack = ^DACK;

  assign dack      = DACK[CHANNEL];
  assign rd_strobe = dack & ~IOR_N;
  assign wr_strobe = dack & ~IOW_N;

  // In IDLE the direction about to be latched decides; afterwards ldir does.
  assign xfer_dir  = (state == S_IDLE) ? dir : ldir;

  // A strobe only starts a beat if it matches the direction and the FIFO
  // can take it, so DB_OE can never be driven from an empty TX FIFO.
  assign strobe_ok   = xfer_dir ? (rd_strobe & ~tx_empty) : (wr_strobe & ~rx_full);
  assign strobe_high = ldir ? IOR_N : IOW_N;
  assign xfer_end    = (state == S_STROBE) & strobe_high;
  assign eop_now     = eop_seen | ~EOP_N;

  assign tx_push  = tx_valid & tx_ready;
  assign tx_pop   = xfer_end & ldir;
  assign rx_push  = xfer_end & ~ldir;
  assign rx_pop   = rx_valid & rx_ready;
  assign tx_ready = ~tx_full;
  assign rx_valid = ~rx_empty;

  assign can_idle  = dir ? ~tx_empty : ~rx_full;
  // Demand mode continuation looks at the FIFO level after this beat.
  assign can_after = ldir ? (tx_cnt_nxt != '0) : (rx_cnt_nxt != FIFO_DEPTH[CW-1:0]);

  dma_io_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .count_nxt (tx_cnt_nxt),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  dma_io_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (rx_push),
    .push_data (cap),
    .pop       (rx_pop),
    .head      (rx_data),
    .count_nxt (rx_cnt_nxt),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable && armed && can_idle) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (!enable)   state_nxt = S_IDLE;
        else if (dack) state_nxt = S_ACK;
      end
      S_ACK: begin
        if (!dack)          state_nxt = S_IDLE;
        else if (strobe_ok) state_nxt = S_STROBE;
      end
      S_STROBE: begin
        if (strobe_high) begin
          if (eop_now)                                    state_nxt = S_DONE;
          else if ((DEMAND_MODE != 0) && can_after && dack) state_nxt = S_ACK;
          else                                            state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!dack) state_nxt = S_IDLE;
      end
      S_DONE: begin
        state_nxt = S_RELEASE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: DREQ is a decode of the state register, so it changes only on
  // clock edges; DB_OE/DB_OUT follow the read strobe combinationally.
  always_comb begin
    DREQ          = '0;
    DREQ[CHANNEL] = (state == S_REQ) || (state == S_ACK) || (state == S_STROBE);
    done          = (state == S_DONE);
    DB_OE         = ((state == S_ACK) || (state == S_STROBE)) & ldir & rd_strobe & ~tx_empty;
    DB_OUT        = DB_OE ? tx_head : '0;
    state_dbg     = state;
  end

  // Transfer bookkeeping
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ldir     <= 1'b0;
      cap      <= '0;
      eop_seen <= 1'b0;
      armed    <= 1'b1;
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable;

      if (state == S_IDLE) ldir <= dir;

      // Keep the most recent bus value seen while the write strobe is low.
      if (((state == S_ACK) || (state == S_STROBE)) && !ldir && wr_strobe) begin
        cap <= DB_IN;
      end

      if ((state == S_IDLE) || (state == S_DONE)) begin
        eop_seen <= 1'b0;
      end else if (((state == S_ACK) || (state == S_STROBE)) && !EOP_N) begin
        eop_seen <= 1'b1;
      end

      // After EOP the device stays quiet until software re-arms it.
      if (state == S_DONE)          armed <= 1'b0;
      else if (enable && !enable_q) armed <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dma_io_peripheral.sv
// Bench for dma_io_peripheral: one single-mode instance on channel 2 and
// one demand-mode instance on channel 1 share the bus strobes and data.

module tb_dma_io_peripheral;
  logic       CLK   = 1'b0;
  logic       RESET = 1'b1;
  logic       IOR_N = 1'b1;
  logic       IOW_N = 1'b1;
  logic       EOP_N = 1'b1;
  logic [7:0] DB_IN = 8'h00;
  logic       dir   = 1'b1;
  logic [7:0] tx_data = 8'h00;

  // single-mode instance (channel 2)
  logic [3:0] dack_s = 4'b0000;
  logic       en_s   = 1'b0;
  logic       txv_s  = 1'b0;
  logic       rxr_s  = 1'b0;
  logic [3:0] dreq_s;
  logic [7:0] db_out_s;
  logic       db_oe_s;
  logic       tx_ready_s;
  logic [7:0] rx_data_s;
  logic       rx_valid_s;
  logic       done_s;
  logic [2:0] state_s;

  // demand-mode instance (channel 1)
  logic [3:0] dack_d = 4'b0000;
  logic       en_d   = 1'b0;
  logic       txv_d  = 1'b0;
  logic       rxr_d  = 1'b0;
  logic [3:0] dreq_d;
  logic [7:0] db_out_d;
  logic       db_oe_d;
  logic       tx_ready_d;
  logic [7:0] rx_data_d;
  logic       rx_valid_d;
  logic       done_d;
  logic [2:0] state_d;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];   // bus read data expected from the single-mode instance
  logic [7:0] rx_q[$];    // local RX pops expected from the single-mode instance
  logic [7:0] expd_q[$];  // bus read data expected from the demand-mode instance

  logic [7:0] wr_vec [4] = '{8'h01, 8'h82, 8'hC3, 8'h44};
  logic [7:0] dm_vec [3] = '{8'h10, 8'h20, 8'h30};

  dma_io_peripheral #(.CHANNEL(2), .DATA_W(8), .FIFO_DEPTH(4), .DEMAND_MODE(0)) dut_s (
    .CLK(CLK), .RESET(RESET), .DREQ(dreq_s), .DACK(dack_s), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .EOP_N(EOP_N), .DB_IN(DB_IN), .DB_OUT(db_out_s), .DB_OE(db_oe_s), .enable(en_s), .dir(dir),
    .tx_data(tx_data), .tx_valid(txv_s), .tx_ready(tx_ready_s), .rx_data(rx_data_s),
    .rx_valid(rx_valid_s), .rx_ready(rxr_s), .done(done_s), .state_dbg(state_s)
  );

  dma_io_peripheral #(.CHANNEL(1), .DATA_W(8), .FIFO_DEPTH(4), .DEMAND_MODE(1)) dut_d (
    .CLK(CLK), .RESET(RESET), .DREQ(dreq_d), .DACK(dack_d), .IOR_N(IOR_N), .IOW_N(IOW_N),
    .EOP_N(EOP_N), .DB_IN(DB_IN), .DB_OUT(db_out_d), .DB_OE(db_oe_d), .enable(en_d), .dir(dir),
    .tx_data(tx_data), .tx_valid(txv_d), .tx_ready(tx_ready_d), .rx_data(rx_data_d),
    .rx_valid(rx_valid_d), .rx_ready(rxr_d), .done(done_d), .state_dbg(state_d)
  );

  // clock
  initial begin
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic push_s(input logic [7:0] d);
    tx_data = d;
    txv_s   = 1'b1;
    tick();
    txv_s   = 1'b0;
  endtask

  task automatic push_d(input logic [7:0] d);
    tx_data = d;
    txv_d   = 1'b1;
    tick();
    txv_d   = 1'b0;
  endtask

  // One read beat on the single-mode instance, starting in REQ; ends in RELEASE or DONE.
  task automatic read_xfer_s(input logic eop);
    dack_s = 4'b0100;
    tick();                 // ACK
    IOR_N = 1'b0;
    if (eop) EOP_N = 1'b0;
    tick();                 // STROBE
    IOR_N = 1'b1;
    EOP_N = 1'b1;
    tick();                 // beat ends
  endtask

  // One write beat on the single-mode instance, starting in REQ; ends in IDLE.
  task automatic write_xfer_s(input logic [7:0] d);
    dack_s = 4'b0100;
    tick();                 // ACK
    DB_IN = d;
    IOW_N = 1'b0;
    tick();                 // STROBE
    IOW_N = 1'b1;
    DB_IN = ~d;             // only the value held during the strobe may land
    tick();                 // RELEASE, RX push
    dack_s = 4'b0000;
    tick();                 // IDLE
  endtask

  // scoreboard monitor: compares whenever a DUT presents data
  initial begin
    logic oe_prev_s;
    logic oe_prev_d;
    logic [7:0] e;
    oe_prev_s = 1'b0;
    oe_prev_d = 1'b0;
    forever begin
      @(negedge CLK);
      if (db_oe_s && !oe_prev_s) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL db_out_s_unexpected: got read of %0h expected no read", db_out_s);
        end else begin
          e = exp_q.pop_front();
          if (db_out_s !== e) begin
            n_err++;
            $display("FAIL db_out_s: got %0h expected %0h", db_out_s, e);
          end
        end
      end
      if (db_oe_d && !oe_prev_d) begin
        n_cmp++;
        if (expd_q.size() == 0) begin
          n_err++;
          $display("FAIL db_out_d_unexpected: got read of %0h expected no read", db_out_d);
        end else begin
          e = expd_q.pop_front();
          if (db_out_d !== e) begin
            n_err++;
            $display("FAIL db_out_d: got %0h expected %0h", db_out_d, e);
          end
        end
      end
      if (rx_valid_s && rxr_s) begin
        n_cmp++;
        if (rx_q.size() == 0) begin
          n_err++;
          $display("FAIL rx_data_s_unexpected: got pop of %0h expected no data", rx_data_s);
        end else begin
          e = rx_q.pop_front();
          if (rx_data_s !== e) begin
            n_err++;
            $display("FAIL rx_data_s: got %0h expected %0h", rx_data_s, e);
          end
        end
      end
      oe_prev_s = db_oe_s;
      oe_prev_d = db_oe_d;
    end
  end

  // stimulus
  initial begin
    // reset
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    check("rst_dreq", {28'd0, dreq_s}, 32'h0);
    check("rst_db_oe", {31'd0, db_oe_s}, 32'h0);
    check("rst_db_out", {24'd0, db_out_s}, 32'h0);
    check("rst_tx_ready", {31'd0, tx_ready_s}, 32'h1);
    check("rst_rx_valid", {31'd0, rx_valid_s}, 32'h0);
    check("rst_done", {31'd0, done_s}, 32'h0);
    check("rst_state", {29'd0, state_s}, 32'h0);

    // 1: single read of 0xA5 on channel 2
    push_s(8'hA5);
    exp_q.push_back(8'hA5);
    dir  = 1'b1;
    en_s = 1'b1;
    check("t1_dreq_before", {28'd0, dreq_s}, 32'h0);
    tick();
    check("t1_dreq_req", {28'd0, dreq_s}, 32'h4);
    dack_s = 4'b0100;
    tick();
    check("t1_state_ack", {29'd0, state_s}, 32'h2);
    IOW_N = 1'b0;           // wrong strobe type: ignored
    tick();
    IOW_N = 1'b1;
    check("t1_wrong_strobe_state", {29'd0, state_s}, 32'h2);
    check("t1_wrong_strobe_rx", {31'd0, rx_valid_s}, 32'h0);
    IOR_N = 1'b0;
    tick();
    check("t1_db_oe", {31'd0, db_oe_s}, 32'h1);
    tick();
    check("t1_db_out", {24'd0, db_out_s}, 32'hA5);
    IOR_N = 1'b1;
    tick();
    check("t1_dreq_after", {28'd0, dreq_s}, 32'h0);
    check("t1_state_release", {29'd0, state_s}, 32'h4);
    dack_s = 4'b0000;
    tick();
    tick();
    check("t1_tx_empty_no_req", {28'd0, dreq_s}, 32'h0);

    // 2: single write of 0x3C
    dir = 1'b0;
    tick();
    check("t2_dreq_req", {28'd0, dreq_s}, 32'h4);
    dack_s = 4'b0100;
    tick();
    DB_IN = 8'h3C;
    IOW_N = 1'b0;
    tick();
    tick();
    IOW_N = 1'b1;
    DB_IN = 8'hFF;
    tick();
    check("t2_rx_valid", {31'd0, rx_valid_s}, 32'h1);
    check("t2_dreq_release", {28'd0, dreq_s}, 32'h0);
    rx_q.push_back(8'h3C);
    rxr_s = 1'b1;
    tick();
    rxr_s = 1'b0;
    check("t2_rx_drained", {31'd0, rx_valid_s}, 32'h0);
    tick();
    check("t2_dreq_dack_held", {28'd0, dreq_s}, 32'h0);
    en_s   = 1'b0;
    dack_s = 4'b0000;
    tick();
    tick();
    check("t2_state_idle", {29'd0, state_s}, 32'h0);

    // 4: EOP on the second transfer, then re-arm
    push_s(8'h11);
    push_s(8'h22);
    push_s(8'h33);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    dir  = 1'b1;
    en_s = 1'b1;
    tick();
    check("t4_dreq_first", {28'd0, dreq_s}, 32'h4);
    read_xfer_s(1'b0);
    check("t4_dreq_after_first", {28'd0, dreq_s}, 32'h0);
    dack_s = 4'b0000;
    tick();
    tick();
    check("t4_dreq_second", {28'd0, dreq_s}, 32'h4);
    read_xfer_s(1'b1);
    check("t4_done", {31'd0, done_s}, 32'h1);
    check("t4_dreq_done", {28'd0, dreq_s}, 32'h0);
    tick();
    check("t4_done_once", {31'd0, done_s}, 32'h0);
    dack_s = 4'b0000;
    repeat (3) tick();
    check("t4_disarmed", {28'd0, dreq_s}, 32'h0);
    check("t4_disarmed_state", {29'd0, state_s}, 32'h0);
    en_s = 1'b0;
    tick();
    en_s = 1'b1;
    tick();
    tick();
    check("t4_rearmed", {28'd0, dreq_s}, 32'h4);
    exp_q.push_back(8'h33);
    read_xfer_s(1'b0);
    dack_s = 4'b0000;
    tick();
    en_s = 1'b0;
    tick();

    // 5: RX full blocks DREQ until one pop
    dir  = 1'b0;
    en_s = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      write_xfer_s(wr_vec[i]);
      rx_q.push_back(wr_vec[i]);
      tick();
    end
    check("t5_full_no_req", {28'd0, dreq_s}, 32'h0);
    check("t5_tx_ready", {31'd0, tx_ready_s}, 32'h1);
    tick();
    check("t5_full_no_req_2", {28'd0, dreq_s}, 32'h0);
    rxr_s = 1'b1;
    tick();
    rxr_s = 1'b0;
    check("t5_pop_edge", {28'd0, dreq_s}, 32'h0);
    tick();
    check("t5_req_after_pop", {28'd0, dreq_s}, 32'h4);
    en_s = 1'b0;
    tick();
    rxr_s = 1'b1;
    repeat (3) tick();
    rxr_s = 1'b0;
    check("t5_rx_empty", {31'd0, rx_valid_s}, 32'h0);

    // 3: demand mode, three reads under one DACK
    for (int i = 0; i < 3; i++) begin
      push_d(dm_vec[i]);
      expd_q.push_back(dm_vec[i]);
    end
    dir  = 1'b1;
    en_d = 1'b1;
    tick();
    check("t3_dreq_req", {28'd0, dreq_d}, 32'h2);
    dack_d = 4'b0010;
    tick();
    for (int i = 0; i < 3; i++) begin
      IOR_N = 1'b0;
      tick();
      IOR_N = 1'b1;
      tick();
      if (i < 2) begin
        check($sformatf("t3_dreq_held_%0d", i), {28'd0, dreq_d}, 32'h2);
        check($sformatf("t3_state_ack_%0d", i), {29'd0, state_d}, 32'h2);
      end else begin
        check("t3_dreq_drop", {28'd0, dreq_d}, 32'h0);
      end
    end
    check("t3_single_quiet", {28'd0, dreq_s}, 32'h0);
    dack_d = 4'b0000;
    en_d   = 1'b0;
    tick();

    // 6: reset in the middle of a read strobe
    push_s(8'h5A);
    exp_q.push_back(8'h5A);
    dir  = 1'b1;
    en_s = 1'b1;
    tick();
    dack_s = 4'b0100;
    tick();
    IOR_N = 1'b0;
    tick();
    check("t6_in_strobe", {29'd0, state_s}, 32'h3);
    check("t6_db_oe_before", {31'd0, db_oe_s}, 32'h1);
    RESET = 1'b1;
    tick();
    check("t6_db_oe", {31'd0, db_oe_s}, 32'h0);
    check("t6_dreq", {28'd0, dreq_s}, 32'h0);
    check("t6_tx_ready", {31'd0, tx_ready_s}, 32'h1);
    check("t6_rx_valid", {31'd0, rx_valid_s}, 32'h0);
    RESET  = 1'b0;
    IOR_N  = 1'b1;
    dack_s = 4'b0000;
    tick();
    tick();
    check("t6_tx_discarded", {28'd0, dreq_s}, 32'h0);
    en_s = 1'b0;
    tick();

    // report
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("rx_q_drained", rx_q.size(), 32'd0);
    check("expd_q_drained", expd_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
